// File: rtl/multi_cycle_control.sv
// ---------------------------------------------------------------------------
// multi_cycle_control
//
// Control unit for a classic multi-cycle MIPS datapath (lw, sw, R-type,
// beq, j, addi). It is a Moore machine: every datapath control is a pure
// function of the current state, and all of them are held in flops so
// they change only on the rising edge of clk.
//
// Ports
//   clk          single clock, rising-edge active
//   rst          synchronous active-high reset (returns to FETCH)
//   opcode[5:0]  instruction opcode from the instruction register
//   funct[5:0]   R-type function field (not used for sequencing)
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
//   ALUSrcA, RegWrite, RegDst        1-bit datapath controls
//   PCSource[1:0], ALUOp[1:0], ALUSrcB[1:0]   mux / ALU selects
//   state[STATE_W-1:0]  current state encoding, for debug
//   illegal_op   one-cycle pulse after a DECODE with an unsupported opcode
// ---------------------------------------------------------------------------
module multi_cycle_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               IRWrite,
    output logic               ALUSrcA,
    output logic               RegWrite,
    output logic               RegDst,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUOp,
    output logic [1:0]         ALUSrcB,
    output logic [STATE_W-1:0] state,
    output logic               illegal_op
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RCOMP  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
    } ctrl_t;

    state_t state_q;
    state_t next_state;
    ctrl_t  ctrl_q;
    logic   opcode_legal;

    // The function field plays no part in sequencing; folding it into a
    // deliberately unused net keeps the port without leaving it dangling.
    logic unused_funct;
    assign unused_funct = ^funct;

    // Control word for a given state. Anything not named for a state is 0,
    // which also covers the four unused encodings.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_write  = 1'b1;
            end
            DECODE: c.alu_src_b = 2'b11;
            MEMADR, ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            RCOMP: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            ADDIWB: c.reg_write = 1'b1;
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state selection. Opcode is only looked at in DECODE and MEMADR,
    // so it may change freely while the machine is in any other state.
    always_comb begin
        next_state   = FETCH;
        opcode_legal = 1'b0;
        case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: opcode_legal = 1'b1;
            default:                                       opcode_legal = 1'b0;
        endcase
        case (state_q)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     next_state = EXEC;
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    OP_ADDI:      next_state = ADDIEX;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR: next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  next_state = MEMWB;
            EXEC:   next_state = RCOMP;
            ADDIEX: next_state = ADDIWB;
            default: next_state = FETCH;
        endcase
    end

    // State register plus the registered control word. The control word is
    // decoded from the state being entered, so after each edge it matches
    // the state now held. The illegal-opcode flag is raised for the single
    // cycle that follows a DECODE which fell back to FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            ctrl_q     <= decode_ctrl(FETCH);
            illegal_op <= 1'b0;
        end else begin
            state_q    <= next_state;
            ctrl_q     <= decode_ctrl(next_state);
            illegal_op <= (state_q == DECODE) && !opcode_legal;
        end
    end

    assign PCWrite     = ctrl_q.pc_write;
    assign PCWriteCond = ctrl_q.pc_write_cond;
    assign IorD        = ctrl_q.iord;
    assign MemRead     = ctrl_q.mem_read;
    assign MemWrite    = ctrl_q.mem_write;
    assign MemtoReg    = ctrl_q.mem_to_reg;
    assign IRWrite     = ctrl_q.ir_write;
    assign ALUSrcA     = ctrl_q.alu_src_a;
    assign RegWrite    = ctrl_q.reg_write;
    assign RegDst      = ctrl_q.reg_dst;
    assign PCSource    = ctrl_q.pc_source;
    assign ALUOp       = ctrl_q.alu_op;
    assign ALUSrcB     = ctrl_q.alu_src_b;
    assign state       = STATE_W'(state_q);

endmodule

// File: tb/tb_multi_cycle_control.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_control
//
// Directed bench for multi_cycle_control. Each scenario task walks one
// instruction through the machine, checking the state, the full control
// word and illegal_op on every falling edge against hand-written values.
// Each task starts and ends on a falling edge with the machine in FETCH.
// ---------------------------------------------------------------------------
module tb_multi_cycle_control;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic [3:0] state;
    logic       illegal_op;

    int checks = 0;
    int errors = 0;

    logic [15:0] obs;

    multi_cycle_control #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcB(ALUSrcB), .state(state), .illegal_op(illegal_op)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed control word, in the same field order as exp_ctrl below.
    assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                  IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB};

    // Required control word per state, written out by hand.
    // Layout: PW PWC IorD MR MW MtR IRW SrcA RW RD _ PCSrc _ ALUOp _ SrcB
    function automatic logic [15:0] exp_ctrl(input logic [3:0] s);
        case (s)
            4'd0:    return 16'b1001001000_00_00_01;
            4'd1:    return 16'b0000000000_00_00_11;
            4'd2:    return 16'b0000000100_00_00_10;
            4'd3:    return 16'b0011000000_00_00_00;
            4'd4:    return 16'b0000010010_00_00_00;
            4'd5:    return 16'b0010100000_00_00_00;
            4'd6:    return 16'b0000000100_00_10_00;
            4'd7:    return 16'b0000000011_00_00_00;
            4'd8:    return 16'b0100000100_01_01_00;
            4'd9:    return 16'b1000000000_10_00_00;
            4'd10:   return 16'b0000000100_00_00_10;
            4'd11:   return 16'b0000000010_00_00_00;
            default: return 16'b0000000000_00_00_00;
        endcase
    endfunction

    // Reset held for two edges: FETCH with its controls and no illegal flag.
    task automatic test_reset();
        rst    = 1'b1;
        opcode = 6'b100011;
        funct  = 6'h00;
        repeat (2) @(negedge clk);
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("[TB] FAIL reset_state got %0d want 0", state);
        end
        checks++;
        if (obs !== exp_ctrl(4'd0)) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b want %b", obs, exp_ctrl(4'd0));
        end
        checks++;
        if (illegal_op !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_illegal got %b want 0", illegal_op);
        end
        rst = 1'b0;
    endtask

    // lw: 0,1,2,3,4,0. Opcode is scrambled in MEMRD to show it is ignored.
    task automatic test_lw();
        logic [3:0] seq [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        opcode = 6'b100011;
        funct  = 6'h2a;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (state !== seq[i]) begin
                errors++;
                $display("[TB] FAIL lw_state[%0d] got %0d want %0d", i, state, seq[i]);
            end
            checks++;
            if (obs !== exp_ctrl(seq[i])) begin
                errors++;
                $display("[TB] FAIL lw_ctrl[%0d] got %b want %b", i, obs, exp_ctrl(seq[i]));
            end
            checks++;
            if (illegal_op !== 1'b0) begin
                errors++;
                $display("[TB] FAIL lw_illegal[%0d] got %b want 0", i, illegal_op);
            end
            if (seq[i] == 4'd3) opcode = 6'b000000;
        end
    endtask

    // sw: 0,1,2,5,0. MEMADR must pick MEMWR for any opcode other than lw.
    task automatic test_sw();
        logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        opcode = 6'b101011;
        funct  = 6'h15;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (state !== seq[i]) begin
                errors++;
                $display("[TB] FAIL sw_state[%0d] got %0d want %0d", i, state, seq[i]);
            end
            checks++;
            if (obs !== exp_ctrl(seq[i])) begin
                errors++;
                $display("[TB] FAIL sw_ctrl[%0d] got %b want %b", i, obs, exp_ctrl(seq[i]));
            end
            checks++;
            if (illegal_op !== 1'b0) begin
                errors++;
                $display("[TB] FAIL sw_illegal[%0d] got %b want 0", i, illegal_op);
            end
        end
    endtask

    // beq then j: 0,1,8,0,1,9,0. The opcode is junk during FETCH and only
    // becomes valid in DECODE, which is the only point it is sampled.
    task automatic test_beq_j();
        logic [3:0] seq [7] = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd9, 4'd0};
        logic [5:0] ops [7] = '{6'b111111, 6'b000100, 6'b000100, 6'b110000,
                                6'b000010, 6'b000010, 6'b000010};
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (state !== seq[i]) begin
                errors++;
                $display("[TB] FAIL beqj_state[%0d] got %0d want %0d", i, state, seq[i]);
            end
            checks++;
            if (obs !== exp_ctrl(seq[i])) begin
                errors++;
                $display("[TB] FAIL beqj_ctrl[%0d] got %b want %b", i, obs, exp_ctrl(seq[i]));
            end
            checks++;
            if (illegal_op !== 1'b0) begin
                errors++;
                $display("[TB] FAIL beqj_illegal[%0d] got %b want 0", i, illegal_op);
            end
            opcode = ops[i];
        end
    endtask

    // Unsupported opcode: 0,1,0 with illegal_op high only in the FETCH that
    // follows DECODE, then a legal beq whose DECODE shows the flag cleared.
    task automatic test_illegal();
        logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd8};
        logic       ill [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        opcode = 6'b111111;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (state !== seq[i]) begin
                errors++;
                $display("[TB] FAIL illegal_state[%0d] got %0d want %0d", i, state, seq[i]);
            end
            checks++;
            if (obs !== exp_ctrl(seq[i])) begin
                errors++;
                $display("[TB] FAIL illegal_ctrl[%0d] got %b want %b", i, obs, exp_ctrl(seq[i]));
            end
            checks++;
            if (illegal_op !== ill[i]) begin
                errors++;
                $display("[TB] FAIL illegal_flag[%0d] got %b want %b", i, illegal_op, ill[i]);
            end
            checks++;
            if (RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
                errors++;
                $display("[TB] FAIL illegal_writes[%0d] got RW=%b MW=%b want 0 0", i, RegWrite, MemWrite);
            end
            if (i == 2) opcode = 6'b000100;
        end
        @(negedge clk);
    endtask

    // Reset while in MEMRD, then an R-type runs 0,1,6,7,0.
    task automatic test_reset_mid();
        logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        opcode = 6'b100011;
        repeat (3) @(negedge clk);
        checks++;
        if (state !== 4'd3) begin
            errors++;
            $display("[TB] FAIL rstmid_pre got %0d want 3", state);
        end
        rst    = 1'b1;
        opcode = 6'b000000;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (state !== seq[i]) begin
                errors++;
                $display("[TB] FAIL rstmid_state[%0d] got %0d want %0d", i, state, seq[i]);
            end
            checks++;
            if (obs !== exp_ctrl(seq[i])) begin
                errors++;
                $display("[TB] FAIL rstmid_ctrl[%0d] got %b want %b", i, obs, exp_ctrl(seq[i]));
            end
            checks++;
            if (illegal_op !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rstmid_illegal[%0d] got %b want 0", i, illegal_op);
            end
        end
    endtask

    // R-type then addi: 0,1,6,7,0,1,10,11,0.
    task automatic test_rtype_addi();
        logic [3:0] seq [9] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
        opcode = 6'b000000;
        funct  = 6'h20;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (state !== seq[i]) begin
                errors++;
                $display("[TB] FAIL raddi_state[%0d] got %0d want %0d", i, state, seq[i]);
            end
            checks++;
            if (obs !== exp_ctrl(seq[i])) begin
                errors++;
                $display("[TB] FAIL raddi_ctrl[%0d] got %b want %b", i, obs, exp_ctrl(seq[i]));
            end
            checks++;
            if (illegal_op !== 1'b0) begin
                errors++;
                $display("[TB] FAIL raddi_illegal[%0d] got %b want 0", i, illegal_op);
            end
            if (i == 3) opcode = 6'b001000;
        end
    endtask

    // Scenario sequence, then the single summary line.
    initial begin
        rst    = 1'b1;
        opcode = 6'b000000;
        funct  = 6'b000000;
        @(negedge clk);
        test_reset();
        test_lw();
        test_sw();
        test_beq_j();
        test_illegal();
        test_reset_mid();
        test_rtype_addi();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have parameter STATE_W, default 4, which sets the width of the state output.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port opcode, input, 6 bits: the instruction opcode held by the instruction register.
REQ-005 SHALL have port funct, input, 6 bits: the R-type function field; it is unused for sequencing and is passed to nothing.
REQ-006 SHALL have outputs PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, each 1 bit: datapath controls.
REQ-007 SHALL have outputs PCSource, ALUOp and ALUSrcB, each 2 bits: datapath mux and ALU controls.
REQ-008 SHALL have output state, STATE_W bits: the current state encoding, for debug.
REQ-009 SHALL have output illegal_op, 1 bit: a registered pulse flagging an unsupported opcode.

Function
REQ-010 SHALL be a Moore FSM; all datapath controls SHALL be decoded from the current state only.
REQ-011 SHALL use the state encodings FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RCOMP=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
REQ-012 SHALL transition FETCH->DECODE unconditionally; IRWrite is asserted in FETCH, so opcode is valid during DECODE.
REQ-013 SHALL branch from DECODE on opcode: 000000->EXEC; 100011 or 101011->MEMADR; 000100->BRANCH; 000010->JUMP; 001000->ADDIEX; any other value->FETCH.
REQ-014 SHALL leave MEMADR for MEMRD when opcode=100011 and for MEMWR otherwise.
REQ-015 SHALL transition MEMRD->MEMWB and EXEC->RCOMP, and ADDIEX->ADDIWB.
REQ-016 SHALL return to FETCH from MEMWB, MEMWR, RCOMP, BRANCH, JUMP and ADDIWB.
REQ-017 SHALL send unused encodings 12-15 to FETCH on the next edge, with all controls 0 while in them.
REQ-018 SHALL drive in FETCH: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCWrite=1, PCSource=00.
REQ-019 SHALL drive in DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-020 SHALL drive in MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-021 SHALL drive in MEMRD: MemRead=1, IorD=1; and in MEMWR: MemWrite=1, IorD=1.
REQ-022 SHALL drive in MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
REQ-023 SHALL drive in EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
REQ-024 SHALL drive in RCOMP: RegWrite=1, RegDst=1, MemtoReg=0; and in ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0.
REQ-025 SHALL drive in BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
REQ-026 SHALL drive in JUMP: PCWrite=1, PCSource=10.
REQ-027 SHALL drive every control not listed for a state to 0.
REQ-028 SHALL set illegal_op to 1 for exactly the one cycle following a DECODE whose opcode is unsupported, and 0 at all other times.
REQ-029 SHALL give instruction latencies of 3 cycles for beq and j, 4 for R-type, addi and sw, and 5 for lw.
REQ-030 SHALL sample opcode only in DECODE and MEMADR; opcode changes in other states SHALL have no effect.

Reset
REQ-031 SHALL, when rst=1 at a rising edge, load state=FETCH and illegal_op=0; rst SHALL override every transition, including mid-instruction.
REQ-032 SHALL, after reset, present the FETCH control values of REQ-018; no output SHALL change asynchronously with rst.

Verification
REQ-033 SHALL cover lw: reset, opcode=100011 -> state sequence 0,1,2,3,4,0; MemtoReg=1 and RegWrite=1 only in state 4.
REQ-034 SHALL cover sw: opcode=101011 -> state sequence 0,1,2,5,0; MemWrite=1 and IorD=1 only in state 5.
REQ-035 SHALL cover beq then j: opcode=000100 gives 0,1,8,0 with PCWriteCond=1 and PCSource=01 in state 8; opcode=000010 gives 0,1,9,0 with PCWrite=1 and PCSource=10.
REQ-036 SHALL cover an illegal opcode: opcode=111111 -> 0,1,0, with illegal_op=1 for one cycle after DECODE and no RegWrite or MemWrite asserted.
REQ-037 SHALL cover reset mid-operation: rst=1 asserted while in MEMRD (state 3) -> state=0 after the next edge with FETCH controls; a normal R-type sequence 0,1,6,7,0 follows.
REQ-038 SHALL cover R-type and addi: opcode=000000 gives 0,1,6,7,0 with ALUOp=10 in state 6 and RegDst=1 in state 7; opcode=001000 gives 0,1,10,11,0 with RegDst=0 in state 11.
